// File: rtl/auto_test_pkg.sv
// Shared types and constants for the parameter auto-test sequencer:
// FSM states, the fixed generator case table and checker LED bit positions.
package auto_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_SETTLE,
        ST_MEASURE,
        ST_WAIT_RES,
        ST_CAPTURE,
        ST_NEXT
    } state_t;

    localparam int MAX_CASES = 8;

    // Unused tail entries are zero so a larger NUM_CASES parks the generator.
    localparam logic [15:0] CASE_FREQ [MAX_CASES] = '{
        16'd10, 16'd10, 16'd20, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0
    };
    localparam logic [15:0] CASE_DUTY [MAX_CASES] = '{
        16'd500, 16'd250, 16'd500, 16'd750, 16'd0, 16'd0, 16'd0, 16'd0
    };

    localparam int ALL_PASS_BIT = 5;
    localparam int PARAM_MSB    = 4;
    localparam int PARAM_LSB    = 0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/auto_test_seq_if.sv
// Control/status bundle between the front panel, generator, checker and
// the auto-test sequencer.
interface auto_test_seq_if
    import auto_test_pkg::*;
#(
    parameter int NUM_CASES = 4
);
    logic                   start;
    logic                   abort;
    logic                   meas_valid;
    logic [7:0]             chk_result;
    logic                   gen_en;
    logic [15:0]            gen_freq;
    logic [15:0]            gen_duty;
    logic                   chk_enable;
    logic                   busy;
    logic                   done;
    logic                   aborted;
    logic [2:0]             case_idx;
    logic [NUM_CASES-1:0]   pass_mask;
    logic [NUM_CASES-1:0]   timeout_mask;
    logic [PARAM_MSB:0]     last_fail;

    modport master (
        output start, abort, meas_valid, chk_result,
        input  gen_en, gen_freq, gen_duty, chk_enable, busy, done, aborted,
               case_idx, pass_mask, timeout_mask, last_fail
    );

    modport slave (
        input  start, abort, meas_valid, chk_result,
        output gen_en, gen_freq, gen_duty, chk_enable, busy, done, aborted,
               case_idx, pass_mask, timeout_mask, last_fail
    );
endinterface

// File: rtl/seq_timer.sv
// Saturating up-counter with terminal-count compare; cleared on every
// sequencer state change so each timed state starts from zero.
module seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_terminal,
    output logic             o_tc
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_terminal);
endmodule

// File: rtl/auto_test_seq.sv
// Auto-test sequencer: walks the case table, configures the generator,
// waits for settling and measurement, and records per-case verdicts.
//
// state       | meaning
// ST_IDLE     | waiting for start; results of last run held
// ST_CONFIG   | load generator frequency/duty for case_idx
// ST_SETTLE   | SETTLE_CYCLES of generator settling, checker off
// ST_MEASURE  | checker on, waiting for meas_valid or timeout
// ST_WAIT_RES | RESULT_LAT cycles for chk_result to stabilise
// ST_CAPTURE  | latch pass bit and failing-parameter word
// ST_NEXT     | advance to next case or finish the run
module auto_test_seq
    import auto_test_pkg::*;
#(
    parameter int NUM_CASES      = 4,
    parameter int SETTLE_CYCLES  = 1_000_000,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int RESULT_LAT     = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    auto_test_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_W-1:0]       w_term;
    logic                   w_tc;
    logic                   w_clear;
    logic                   w_cnt_en;
    logic                   w_abort_take;
    logic                   w_last;
    logic [NUM_CASES-1:0]   w_case_bit;

    logic                   r_gen_en;
    logic [15:0]            r_gen_freq;
    logic [15:0]            r_gen_duty;
    logic                   r_chk_en;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_aborted;
    logic [2:0]             r_case_idx;
    logic [NUM_CASES-1:0]   r_pass;
    logic [NUM_CASES-1:0]   r_timeout;
    logic [PARAM_MSB:0]     r_last_fail;

    assign w_abort_take = bus.abort && (r_state != ST_IDLE);
    assign w_last       = (r_case_idx == 3'(NUM_CASES - 1));
    assign w_case_bit   = NUM_CASES'(1) << r_case_idx;
    assign w_clear      = (w_next != r_state);
    assign w_cnt_en     = r_state inside {ST_SETTLE, ST_MEASURE, ST_WAIT_RES};

    always_comb begin
        w_term = '0;
        case (r_state)
            ST_SETTLE:   w_term = CNT_W'(SETTLE_CYCLES - 1);
            ST_MEASURE:  w_term = CNT_W'(TIMEOUT_CYCLES - 1);
            ST_WAIT_RES: w_term = CNT_W'(RESULT_LAT - 1);
            default:     w_term = '0;
        endcase
    end

    seq_timer #(.WIDTH(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_enable   (w_cnt_en),
        .i_terminal (w_term),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort_take) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (bus.start && !bus.abort) w_next = ST_CONFIG;
                ST_CONFIG:   w_next = ST_SETTLE;
                ST_SETTLE:   if (w_tc) w_next = ST_MEASURE;
                // meas_valid is tested first so it wins on the timeout cycle
                ST_MEASURE:  if (bus.meas_valid) w_next = ST_WAIT_RES;
                             else if (w_tc)      w_next = ST_NEXT;
                ST_WAIT_RES: if (w_tc) w_next = ST_CAPTURE;
                ST_CAPTURE:  w_next = ST_NEXT;
                ST_NEXT:     w_next = w_last ? ST_IDLE : ST_CONFIG;
                default:     w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen_en    <= 1'b0;
            r_gen_freq  <= '0;
            r_gen_duty  <= '0;
            r_chk_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_case_idx  <= '0;
            r_pass      <= '0;
            r_timeout   <= '0;
            r_last_fail <= '0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_chk_en  <= w_next inside {ST_MEASURE, ST_WAIT_RES, ST_CAPTURE};
            if (w_abort_take) begin
                r_gen_en   <= 1'b0;
                r_gen_freq <= '0;
                r_gen_duty <= '0;
                r_busy     <= 1'b0;
                r_aborted  <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: if (bus.start && !bus.abort) begin
                        r_busy      <= 1'b1;
                        r_case_idx  <= '0;
                        r_pass      <= '0;
                        r_timeout   <= '0;
                        r_last_fail <= '0;
                    end
                    ST_CONFIG: begin
                        r_gen_freq <= CASE_FREQ[r_case_idx];
                        r_gen_duty <= CASE_DUTY[r_case_idx];
                        r_gen_en   <= 1'b1;
                    end
                    ST_MEASURE: if (!bus.meas_valid && w_tc) begin
                        r_timeout   <= r_timeout | w_case_bit;
                        r_last_fail <= '1;
                    end
                    ST_CAPTURE: begin
                        r_pass      <= bus.chk_result[ALL_PASS_BIT] ? (r_pass | w_case_bit)
                                                                    : (r_pass & ~w_case_bit);
                        r_last_fail <= ~bus.chk_result[PARAM_MSB:PARAM_LSB];
                    end
                    ST_NEXT: if (w_last) begin
                        r_gen_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_case_idx <= r_case_idx + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.gen_en       = r_gen_en;
    assign bus.gen_freq     = r_gen_freq;
    assign bus.gen_duty     = r_gen_duty;
    assign bus.chk_enable   = r_chk_en;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.aborted      = r_aborted;
    assign bus.case_idx     = r_case_idx;
    assign bus.pass_mask    = r_pass;
    assign bus.timeout_mask = r_timeout;
    assign bus.last_fail    = r_last_fail;
endmodule

// File: doc/auto_test_seq.md
Name: auto_test_seq

Overview:
Sequencer for the parameter auto-test checker. It steps through a fixed table of test cases. For each case it configures the signal generator (frequency, duty), waits for settling, and enables the checker. It then waits for a measurement, samples the checker's 8-bit pass/fail result, and records a per-case verdict. It sits between the front-panel start/abort controls, the DDS/PWM generator and the checker.

Parameters:
NUM_CASES, 4, number of table entries (1..8).
SETTLE_CYCLES, 1_000_000, clk cycles between generator reconfiguration and checker enable (10 ms at 100 MHz).
TIMEOUT_CYCLES, 50_000_000, maximum cycles in MEASURE waiting for meas_valid.
RESULT_LAT, 3, cycles from the meas_valid pulse to a stable chk_result.

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse; begins a run from case 0
abort  in  1  single-cycle pulse; stops the run
meas_valid  in  1  measurement-complete pulse from the parameter measurement chain
chk_result  in  8  checker LED word; bit5 = all-pass, bits4:0 = per-parameter pass
gen_en  out  1  generator output enable
gen_freq  out  16  generator frequency, Hz
gen_duty  out  16  generator duty, 0..1000 = 0..100%
chk_enable  out  1  checker test enable
busy  out  1  run in progress
done  out  1  one-cycle pulse at normal run completion
aborted  out  1  one-cycle pulse when abort is taken
case_idx  out  3  current case index
pass_mask  out  NUM_CASES  bit i = case i passed
timeout_mask  out  NUM_CASES  bit i = case i timed out
last_fail  out  5  inverted chk_result[4:0] captured for the most recent case

Behaviour:
- Reset values: every output is 0; FSM is in IDLE.
- FSM states: IDLE, CONFIG, SETTLE, MEASURE, WAIT_RES, CAPTURE, NEXT.
- IDLE: start=1 -> CONFIG on the next cycle. Also clears pass_mask, timeout_mask, last_fail and case_idx to 0. busy rises in the same edge.
- CONFIG (1 cycle): load gen_freq/gen_duty from CASE_FREQ[case_idx]/CASE_DUTY[case_idx]; gen_en=1; clear the counter; go to SETTLE.
- SETTLE: the counter counts up. Leave exactly SETTLE_CYCLES cycles after entry, to MEASURE. chk_enable=0 throughout; meas_valid is ignored.
- MEASURE: chk_enable=1; the counter restarts at 0.
  - meas_valid=1 -> WAIT_RES.
  - If the counter reaches TIMEOUT_CYCLES-1 with no meas_valid: set timeout_mask[case_idx]=1, leave pass_mask[case_idx]=0, set last_fail=5'h1F, go to NEXT.
  - If meas_valid coincides with the timeout cycle, meas_valid wins.
- WAIT_RES: hold chk_enable=1 for RESULT_LAT cycles, then go to CAPTURE.
- CAPTURE (1 cycle): pass_mask[case_idx] <= chk_result[5]; last_fail <= ~chk_result[4:0]; go to NEXT.
- NEXT (1 cycle): chk_enable=0.
  - If case_idx==NUM_CASES-1: gen_en=0, busy=0, done pulse, case_idx held, go to IDLE.
  - Otherwise: case_idx+1, go to CONFIG. gen_en stays 1 across cases.
- gen_freq and gen_duty hold their values until the next CONFIG or until abort/reset clears them to 0.
- abort in any non-IDLE state, the next edge:
  - FSM goes to IDLE; gen_en, chk_enable and busy go to 0; gen_freq and gen_duty go to 0.
  - aborted pulses for 1 cycle; done stays low.
  - pass_mask and timeout_mask keep their partial values.
- abort in IDLE is ignored. abort and start in the same cycle: abort wins (no run starts).
- start while busy is ignored.
- Counter width is $clog2(max(SETTLE_CYCLES,TIMEOUT_CYCLES)+1). Counters saturate and never wrap.
- Asynchronous reset mid-run: immediate return to reset values; no done or aborted pulse.

Decomposition:
- Package auto_test_pkg holds:
  - the FSM state enum;
  - the case table CASE_FREQ = {10,10,20,50} and CASE_DUTY = {500,250,500,750}, sized 8 and indexed by case_idx;
  - the chk_result bit-position constants (ALL_PASS_BIT=5, the PARAM_BITS range).
- One natural sub-module: seq_timer, a loadable up-counter with a terminal-count compare, shared by SETTLE, MEASURE and WAIT_RES.

Test Plan:
All scenarios use SETTLE_CYCLES=8, TIMEOUT_CYCLES=64, RESULT_LAT=3, NUM_CASES=4.
- Nominal run: start; meas_valid 5 cycles into each MEASURE; chk_result=8'h3F -> gen_freq sequence 10,10,20,50; pass_mask=4'hF; timeout_mask=0; one done pulse; busy low afterwards; gen_en=0.
- Mixed verdicts: chk_result=8'h1B on case 2 only -> pass_mask=4'b1011; last_fail holds 5'h04 after case 2, then 5'h00 after case 3.
- Timeout: no meas_valid in case 1 -> MEASURE lasts exactly 64 cycles; timeout_mask=4'b0010; pass_mask[1]=0; run continues to done.
- Abort in SETTLE of case 2 -> next edge: busy=0, gen_en=0, gen_freq=0; aborted pulses; no done; pass_mask=4'b0011 retained.
- Settle guard: meas_valid pulsed during SETTLE -> ignored; chk_enable rises exactly 8 cycles after CONFIG.
- Corner cases: start while busy -> no restart; start+abort in the same cycle from IDLE -> stays IDLE; rst_n asserted in WAIT_RES -> all outputs 0 immediately.
